fb_arbiter: RTL and testbench



---
 rtl/fb_arb_pkg.sv | 19 +
 rtl/fb_wr_fifo.sv | 55 +++++
 rtl/fb_arbiter.sv | 145 ++++++++++++++
 tb/tb_fb_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// fb_arbiter shared types: slot encoding and posted-write entry.
package fb_arb_pkg;

    localparam int FB_DW = 48;
    localparam int FB_AW = 15;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_WRITE,
        SLOT_FORCE
    } slot_e;

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [FB_DW-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Posted-write FIFO; exposes all entries oldest-first for address compare.
module fb_wr_fifo
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  wr_entry_t               din,
    output wr_entry_t               head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output wr_entry_t [DEPTH-1:0]   ents,
    output logic [DEPTH-1:0]        ent_valid
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wp;
    logic [PW:0] rp;
    wr_entry_t   mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wp[PW-1:0]] <= din;
    end

    assign empty = (wp == rp);
    assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign count = wp - rp;
    assign head  = mem[rp[PW-1:0]];

    // Index 0 is the head; higher indices are progressively newer.
    always_comb begin
        ents      = '0;
        ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ents[i]      = mem[rp[PW-1:0] + PW'(i)];
            ent_valid[i] = ((PW+1)'(i) < count);
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: display reads first, posted host writes drain idle slots.
// Define FB_ARB_BYPASS_EN to forward pending FIFO data to reads of the same address.
module fb_arbiter
    import fb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DW,
    parameter int ADDR_WIDTH = FB_AW,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    slot_e                          slot;
    logic                           force_wr;
    logic [SW-1:0]                  starve;
    logic                           push;
    logic                           pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;
    wr_entry_t                      din;
    wr_entry_t                      head;
    wr_entry_t [FIFO_DEPTH-1:0]     ents;
    logic [FIFO_DEPTH-1:0]          ent_valid;

    assign din      = '{addr: wr_addr, data: wr_data};
    assign wr_ready = !fifo_full;
    assign push     = wr_valid && !fifo_full;

    fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in    (clk_in),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .ents      (ents),
        .ent_valid (ent_valid)
    );

    assign force_wr = (starve == SW'(STARVE_MAX));

    always_comb begin
        slot = SLOT_IDLE;
        if (!rst) begin
            if (force_wr && !fifo_empty)     slot = SLOT_FORCE;
            else if (rd_req && !force_wr)    slot = SLOT_READ;
            else if (!rd_req && !fifo_empty) slot = SLOT_WRITE;
        end
    end

    always_comb begin
        rd_gnt    = 1'b0;
        pop       = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (slot)
            SLOT_READ: begin
                rd_gnt   = 1'b1;
                ram_addr = rd_addr;
            end
            SLOT_WRITE, SLOT_FORCE: begin
                pop       = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = head.addr;
                ram_wdata = head.data;
            end
            default: ;
        endcase
    end

    // Counts reads that overtook a waiting write; a pop or empty FIFO resets it.
    always_ff @(posedge clk_in) begin
        if (rst)
            starve <= '0;
        else if (pop || fifo_empty)
            starve <= '0;
        else if (slot == SLOT_READ && !force_wr)
            starve <= starve + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst) rd_valid <= 1'b0;
        else     rd_valid <= rd_gnt;
    end

`ifdef FB_ARB_BYPASS_EN
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;
    logic                  byp_hit_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic                  unused_view;

    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i] && !(pop && i == 0) && ents[i].addr == rd_addr) begin
                byp_hit  = 1'b1;
                byp_data = ents[i].data;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= rd_gnt && byp_hit;
            byp_data_q <= byp_data;
        end
    end

    assign rd_data     = !rd_valid ? '0 : (byp_hit_q ? byp_data_q : ram_rdata);
    assign unused_view = ^fifo_count;
`else
    logic unused_view;

    assign rd_data     = rd_valid ? ram_rdata : '0;
    assign unused_view = ^{fifo_count, ents, ent_valid};
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter with a behavioural RAM and reference arbiter.
module tb_fb_arbiter;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [14:0] rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [47:0] rd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [47:0] wr_data;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [47:0] ram_wdata;
    logic [47:0] ram_rdata;

    always #5 clk_in = ~clk_in;

    fb_arbiter dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    logic [47:0] ram [32768];
    logic [47:0] ref_mem [32768];

    always @(posedge clk_in) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    typedef struct {
        logic [14:0] a;
        logic [47:0] d;
    } ent_t;

    ent_t        ref_q [$];
    logic [47:0] rd_q [$];
    int          starve_m = 0;
    logic        rv_m = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        ent_t        e;
        logic        m_empty;
        logic        m_full;
        logic        m_force;
        logic        gnt;
        logic        pop_m;
        logic [47:0] exp_d;
        @(negedge clk_in);
        m_empty = (ref_q.size() == 0);
        m_full  = (ref_q.size() == 4);
        m_force = (starve_m == 8);
        gnt     = 1'b0;
        pop_m   = 1'b0;
        if (!rst) begin
            if (m_force && !m_empty)     pop_m = 1'b1;
            else if (rd_req && !m_force) gnt   = 1'b1;
            else if (!rd_req && !m_empty) pop_m = 1'b1;
        end
        chk("wr_ready", wr_ready, !m_full);
        chk("rd_gnt", rd_gnt, gnt);
        chk("ram_we", ram_we, pop_m);
        if (pop_m) begin
            e = ref_q[0];
            chk("wr_addr", ram_addr, e.a);
            chk("wr_data", ram_wdata, e.d);
        end else begin
            chk("ram_addr", ram_addr, gnt ? rd_addr : 15'd0);
            chk("ram_wdata", ram_wdata, 0);
        end
        if (rv_m) begin
            chk("rd_valid", rd_valid, 1);
            if (rd_q.size() == 0) chk("rd_q_empty", 1, 0);
            else chk("rd_data", rd_data, rd_q.pop_front());
        end else begin
            chk("rd_quiet", {rd_valid, rd_data}, 0);
        end
        if (gnt) begin
            exp_d = ref_mem[rd_addr];
`ifdef FB_ARB_BYPASS_EN
            foreach (ref_q[i]) if (ref_q[i].a == rd_addr) exp_d = ref_q[i].d;
`endif
            rd_q.push_back(exp_d);
        end
        @(posedge clk_in);
        if (rst) begin
            ref_q.delete();
            starve_m = 0;
            rv_m     = 1'b0;
        end else begin
            if (pop_m) begin
                e = ref_q.pop_front();
                ref_mem[e.a] = e.d;
            end
            if (wr_valid && !m_full) ref_q.push_back('{wr_addr, wr_data});
            if (pop_m || m_empty)       starve_m = 0;
            else if (gnt && starve_m < 8) starve_m++;
            rv_m = gnt;
        end
        #1;
    endtask

    initial begin
        logic [63:0] r64;
        for (int i = 0; i < 32768; i++) begin
            ram[i]     = 48'(i + 1);
            ref_mem[i] = 48'(i + 1);
        end
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk_in);
        #1;
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // Display reads, data = addr + 1
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1; rd_addr = 15'(16 + i);
            cycle();
        end
        rd_req = 1'b0;
        repeat (2) cycle();

        // Write drain with no reads
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1; wr_addr = 15'(i); wr_data = 48'(32'hA0 + i);
            cycle();
        end
        wr_valid = 1'b0;
        repeat (6) cycle();

        // Single entry starved by a continuous reader
        wr_valid = 1'b1; wr_addr = 15'h7; wr_data = 48'h77;
        cycle();
        wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 15'h30;
        repeat (12) cycle();
        rd_req = 1'b0;
        repeat (2) cycle();

        // Full FIFO under reads, writer keeps pushing through forced pops
        rd_req = 1'b1; rd_addr = 15'h40; wr_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            wr_addr = 15'(16'h50 + i); wr_data = 48'($urandom);
            cycle();
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        repeat (8) cycle();

        // Read of an address with a pending write
        rd_req = 1'b1; rd_addr = 15'h20;
        wr_valid = 1'b1; wr_addr = 15'h5; wr_data = 48'h1234;
        cycle();
        wr_valid = 1'b0; rd_addr = 15'h5;
        repeat (2) cycle();
        rd_req = 1'b0;
        repeat (3) cycle();
        rd_req = 1'b1;
        cycle();
        rd_req = 1'b0;
        repeat (2) cycle();

        // Reset in the middle of traffic
        rd_req = 1'b1; rd_addr = 15'h60; wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = 15'(16'h70 + i); wr_data = 48'(16'hBEE0 + i);
            cycle();
        end
        rst = 1'b1; wr_valid = 1'b0;
        cycle();
        rst = 1'b0; rd_req = 1'b0;
        repeat (3) cycle();

        // Random traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            rd_req   = ($urandom_range(0, 2) != 0);
            rd_addr  = 15'($urandom_range(0, 15));
            wr_valid = $urandom_range(0, 1) == 1;
            wr_addr  = 15'($urandom_range(0, 15));
            r64      = {$urandom, $urandom};
            wr_data  = r64[47:0];
            cycle();
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
